// File: rtl/ml_demod_pkg.sv
// Shared definitions for the demodulator back end: LLR geometry, the packed
// vector layout and the per-beat protocol check.
package ml_demod_pkg;

    localparam int LLR_W        = 8;
    localparam int BITS_PER_VEC = 8;
    localparam int VEC_LLR_W    = LLR_W * BITS_PER_VEC;
    localparam int IDX_W_DEF    = 10;

    typedef struct packed {
        logic [IDX_W_DEF-1:0]    idx;
        logic [BITS_PER_VEC-1:0] hb;
        logic [VEC_LLR_W-1:0]    llr;
    } packed_vec_t;

    // A beat is malformed when its hard bit disagrees with the LLR sign or the LLR carries no information.
    function automatic logic llr_sign_bad(input logic [LLR_W-1:0] llr, input logic hard_bit);
        return (hard_bit != llr[LLR_W-1]) || (llr == 8'h00);
    endfunction

endpackage

// File: rtl/llr_vec_fifo.sv
// Small register-array FIFO for packed vectors; the head is held in its own
// register so downstream sees only flop outputs.
module llr_vec_fifo
    import ml_demod_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int W     = 82
) (
    input  logic         i_clk,
    input  logic         i_reset,
    input  logic         i_push,
    input  logic [W-1:0] i_din,
    input  logic         i_pop,
    output logic         o_full,
    output logic         o_empty,
    output logic [W-1:0] o_head
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [W-1:0]     r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic [W-1:0]     r_head;

    logic             w_push;
    logic             w_pop;
    logic [PTR_W-1:0] w_rd_next;
    logic [CNT_W-1:0] w_count_next;
    logic [CNT_W-1:0] w_count_after_pop;

    assign o_full            = (r_count == CNT_W'(DEPTH));
    assign o_empty           = (r_count == CNT_W'(0));
    assign o_head            = r_head;
    assign w_push            = i_push && !o_full;
    assign w_pop             = i_pop && !o_empty;
    assign w_rd_next         = r_rd_ptr + PTR_W'(1);
    assign w_count_after_pop = r_count - CNT_W'(w_pop);

    // Occupancy update for push, pop, or both at once.
    always_comb begin
        w_count_next = r_count;
        case ({w_push, w_pop})
            2'b10:   w_count_next = r_count + CNT_W'(1);
            2'b01:   w_count_next = r_count - CNT_W'(1);
            default: w_count_next = r_count;
        endcase
    end

    // Storage array and pointers.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= i_din;
                r_wr_ptr        <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= w_rd_next;
            end
            r_count <= w_count_next;
        end
    end

    // Head register: a push into a FIFO that would otherwise be empty lands here directly.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_head <= '0;
        end else if (w_push && (w_count_after_pop == CNT_W'(0))) begin
            r_head <= i_din;
        end else if (w_pop) begin
            r_head <= r_mem[w_rd_next];
        end else begin
            r_head <= r_head;
        end
    end

endmodule

// File: rtl/llr_vector_packer.sv
// Packs the serial LLR/hard-bit stream into 8-beat vectors, tags each with a
// sequence index and queues them for the decoder; flags malformed beats.
module llr_vector_packer
    import ml_demod_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int IDX_W = 10
) (
    input  logic                    i_clk,
    input  logic                    i_reset,
    input  logic                    i_llr_vld,
    output logic                    o_llr_rdy,
    input  logic [LLR_W-1:0]        i_llr,
    input  logic                    i_hard_bit,
    output logic                    o_out_vld,
    input  logic                    i_out_rdy,
    output logic [VEC_LLR_W-1:0]    o_out_llr,
    output logic [BITS_PER_VEC-1:0] o_out_hb,
    output logic [IDX_W-1:0]        o_out_idx,
    output logic                    o_sign_err
);

    // Payload layout follows packed_vec_t: {idx, hb, llr}.
    localparam int PAY_W = IDX_W + BITS_PER_VEC + VEC_LLR_W;
    localparam int SH_W  = VEC_LLR_W - LLR_W;

    logic [2:0]              r_cnt;
    logic [SH_W-1:0]         r_llr_sh;
    logic [BITS_PER_VEC-2:0] r_hb_sh;
    logic [IDX_W-1:0]        r_vec_idx;
    logic                    r_sign_err;

    logic                    w_acc;
    logic                    w_push;
    logic                    w_pop;
    logic                    w_full;
    logic                    w_empty;
    logic [PAY_W-1:0]        w_din;
    logic [PAY_W-1:0]        w_head;

    // The last beat waits for FIFO space; a same-cycle pop is deliberately not looked at.
    assign o_llr_rdy = (r_cnt != 3'd7) || !w_full;
    assign w_acc     = i_llr_vld && o_llr_rdy;
    assign w_push    = w_acc && (r_cnt == 3'd7);
    assign w_pop     = !w_empty && i_out_rdy;
    assign w_din     = {r_vec_idx, i_hard_bit, r_hb_sh, i_llr, r_llr_sh};

    assign o_out_vld  = !w_empty;
    assign o_out_llr  = w_head[VEC_LLR_W-1:0];
    assign o_out_hb   = w_head[VEC_LLR_W +: BITS_PER_VEC];
    assign o_out_idx  = w_head[PAY_W-1 -: IDX_W];
    assign o_sign_err = r_sign_err;

    // Assembly shadow, beat counter and vector index.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_cnt     <= 3'd0;
            r_llr_sh  <= '0;
            r_hb_sh   <= '0;
            r_vec_idx <= '0;
        end else if (w_acc) begin
            if (r_cnt != 3'd7) begin
                r_llr_sh[{r_cnt, 3'b000} +: LLR_W] <= i_llr;
                r_hb_sh[r_cnt]                    <= i_hard_bit;
            end else begin
                r_vec_idx <= r_vec_idx + IDX_W'(1);
            end
            r_cnt <= r_cnt + 3'd1;
        end
    end

    // Sticky protocol-violation flag.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_sign_err <= 1'b0;
        end else if (w_acc && llr_sign_bad(i_llr, i_hard_bit)) begin
            r_sign_err <= 1'b1;
        end
    end

    llr_vec_fifo #(
        .DEPTH (DEPTH),
        .W     (PAY_W)
    ) u_fifo (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_push  (w_push),
        .i_din   (w_din),
        .i_pop   (w_pop),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_head  (w_head)
    );

endmodule
